range_sample_framer: RTL
========================

// Module: range_sample_framer
// PURPOSE
//  Upstream feeder for the range-finder stage. Deserialises a 1-bit sample stream into WIDTH-bit words.
//  Frames each measurement session as: one-cycle go with the first word, then held data words, then a one-cycle finish.
//  Never issues finish outside a session and never issues go and finish together, so the range finder's error flag stays clear.
// PARAMETERS
//  WIDTH   10  sample word width in bits (>=2)
//  CNT_W   8   width of session word counter (saturating)
// PORTS
//  clock       in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  ser_data    in   1        serial sample bit, MSB first
//  ser_valid   in   1        ser_data valid this cycle
//  start       in   1        request to open a session (level, sampled per cycle)
//  stop        in   1        request to close the open session
//  data_out    out  WIDTH    current sample word to range finder; held between updates
//  go          out  1        one-cycle pulse, coincident with first word of a session
//  finish      out  1        one-cycle pulse closing a session
//  active      out  1        session open (FIRST or RUN)
//  word_count  out  CNT_W    words delivered in current/last session, saturating
//  parity_err  out  1        sticky per session; only with RSF_PARITY_EN, else tied 0
// BEHAVIOUR
//  Reset: state=IDLE, data_out=0, go=0, finish=0, active=0, word_count=0, parity_err=0, bit counter=0.
//  All outputs registered. States: IDLE, FIRST, RUN, CLOSE.
//  IDLE: ser_valid ignored, bit counter held 0. start&~stop -> FIRST, word_count<=0, parity_err<=0.
//   start&stop together in IDLE: ignored, stay IDLE. stop alone: ignored (no finish).
//  FIRST/RUN: each ser_valid cycle shifts ser_data into shift reg, bit counter++.
//   Word completes on the cycle the WIDTH-th bit is accepted; counter wraps to 0 same edge.
//   FIRST, word complete: next cycle data_out=word, go=1 (one cycle), word_count=1, -> RUN.
//   RUN, word complete: next cycle data_out=word, word_count++ (saturate at 2^CNT_W-1). go stays 0.
//   data_out holds between words; repeated samples are harmless to min/max tracking.
//  stop in FIRST: abort -> IDLE, no go, no finish, partial bits discarded.
//  stop in RUN: partial word discarded, bit counter<=0, -> CLOSE. If a word completes same cycle
//   as stop, that word is delivered (data_out updated) and the session still closes.
//  CLOSE: finish=1 for exactly one cycle, data_out held, -> IDLE. start during CLOSE ignored.
//  start while active: ignored. active=1 in FIRST and RUN only.
//  go and finish are never high in the same cycle; a session with zero words emits neither.
//  Reset mid-session: immediate return to IDLE, no finish emitted.
// CONFIGURATION
//  RSF_PARITY_EN defined: each word is followed by one even-parity bit (WIDTH+1 bits per word).
//   Parity fail: word dropped (data_out, go, word_count unchanged; FIRST stays FIRST), parity_err<=1 until next session start.
//  Undefined: WIDTH bits per word, no parity check, parity_err tied 0.
// STRUCTURE
//  Package range_pkg: typedef enum logic [1:0] {IDLE, FIRST, RUN, CLOSE} rsf_state_t;
//   localparam RANGE_WIDTH=10 shared with range finder instantiation.
//  Sub-module serial_deserializer: shift reg + bit counter + (optional) parity check;
//   outputs word, word_done, word_ok. Top holds FSM, output regs, word counter.
// TESTING
//  1 Reset mid-RUN with 2 words delivered -> all outputs 0 next cycle, no finish pulse.
//  2 start, send 0x155 then 0x0AA then 0x3FF, stop -> go with data_out=0x155, then 0x0AA,
//    0x3FF, finish one cycle after stop, word_count=3, go/finish never overlap.
//  3 stop with no start; start&stop same cycle in IDLE -> no go, no finish, active=0.
//  4 start, 5 bits sent, stop -> abort from FIRST: no go, no finish, next session's first word clean.
//  5 stop on same cycle as 10th bit of word 0x200 in RUN -> data_out=0x200 then finish next cycle.
//  6 RSF_PARITY_EN: word 0x001 with parity 0 (bad) then 0x003 with parity 0 -> 0x001 dropped,
//    go with 0x003, parity_err=1; cleared at next start. Also 300 words with CNT_W=8 -> word_count=255.

Source files
------------

// File: rtl/range_pkg.sv
`default_nettype none
// ============================================================================
// Module      : range_pkg
// Description : Shared FSM state type and range-finder word width.
// Revision    : 1.0
// ============================================================================
package range_pkg;

  typedef enum logic [1:0] {IDLE, FIRST, RUN, CLOSE} rsf_state_t;

  localparam int RANGE_WIDTH = 10;

endpackage
`default_nettype wire

// File: rtl/range_sample_framer_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : MSB-first shift register with bit counter; flags each completed
//               word. Optional even-parity trailer bit via RSF_PARITY_EN.
// Revision    : 1.0
// ============================================================================
module serial_deserializer #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             ser_data,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic             word_ok
);

`ifdef RSF_PARITY_EN
  localparam int BITS = WIDTH + 1;
  localparam int SH_W = WIDTH;
`else
  localparam int BITS = WIDTH;
  localparam int SH_W = WIDTH - 1;
`endif
  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] c_last = CW'(BITS - 1);

  logic [SH_W-1:0] r_shift;
  logic [CW-1:0]   r_cnt;
  logic [SH_W:0]   w_cat;
  logic            w_accept;
  logic            w_last;
  logic            w_data_bit;

  // The completing bit is merged combinationally so the word is usable on
  // the same edge that accepts it.
  assign w_cat     = {r_shift, ser_data};
  assign w_accept  = enable & ser_valid;
  assign w_last    = (r_cnt == c_last);
  assign word_done = w_accept & w_last;

`ifdef RSF_PARITY_EN
  assign w_data_bit = ~w_last;
  assign word       = r_shift;
  assign word_ok    = ~^w_cat;
`else
  assign w_data_bit = 1'b1;
  assign word       = w_cat;
  assign word_ok    = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      if (!enable || flush)
        r_cnt <= '0;
      else if (w_accept)
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_accept && w_data_bit)
        r_shift <= w_cat[SH_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/range_sample_framer.sv
`default_nettype none
// ============================================================================
// Module      : range_sample_framer
// Description : Frames deserialised sample words into go/data/finish sessions
//               for the range finder. Parity check enabled by RSF_PARITY_EN.
// Revision    : 1.0
// ============================================================================
module range_sample_framer
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_data,
  input  logic             ser_valid,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             active,
  output logic [CNT_W-1:0] word_count,
  output logic             parity_err
);

  rsf_state_t       r_state;
  rsf_state_t       w_next;
  logic             w_in_session;
  logic [WIDTH-1:0] w_word;
  logic             w_word_done;
  logic             w_word_ok;
  logic             w_good;

  logic [WIDTH-1:0] w_data_nxt;
  logic             w_go_nxt;
  logic             w_fin_nxt;
  logic             w_act_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_perr_nxt;

  assign w_in_session = (r_state == FIRST) || (r_state == RUN);
  assign w_good       = w_word_done & w_word_ok;

  serial_deserializer #(.WIDTH(WIDTH)) u_deser (
    .clock     (clock),
    .reset     (reset),
    .enable    (w_in_session),
    .flush     (stop),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .word      (w_word),
    .word_done (w_word_done),
    .word_ok   (w_word_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start && !stop) w_next = FIRST;
      FIRST:   if (stop) w_next = IDLE;
               else if (w_good) w_next = RUN;
      RUN:     if (stop) w_next = CLOSE;
      CLOSE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are computed from the transition and registered, so finish lands
  // in CLOSE and go lands on the first RUN cycle; they can never coincide.
  always_comb begin
    w_data_nxt = data_out;
    w_go_nxt   = 1'b0;
    w_fin_nxt  = (w_next == CLOSE);
    w_act_nxt  = (w_next == FIRST) || (w_next == RUN);
    w_cnt_nxt  = word_count;
    w_perr_nxt = parity_err;
    case (r_state)
      IDLE: if (start && !stop) begin
        w_cnt_nxt  = '0;
        w_perr_nxt = 1'b0;
      end
      FIRST: if (w_good && !stop) begin
        w_data_nxt = w_word;
        w_go_nxt   = 1'b1;
        w_cnt_nxt  = CNT_W'(1);
      end
      RUN: if (w_good) begin
        w_data_nxt = w_word;
        w_cnt_nxt  = (&word_count) ? word_count : word_count + 1'b1;
      end
      default: ;
    endcase
    if (w_in_session && w_word_done && !w_word_ok)
      w_perr_nxt = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      go         <= 1'b0;
      finish     <= 1'b0;
      active     <= 1'b0;
      word_count <= '0;
    end else begin
      data_out   <= w_data_nxt;
      go         <= w_go_nxt;
      finish     <= w_fin_nxt;
      active     <= w_act_nxt;
      word_count <= w_cnt_nxt;
    end
  end

`ifdef RSF_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= w_perr_nxt;
  end
`else
  logic w_perr_unused;
  assign w_perr_unused = w_perr_nxt;
  assign parity_err    = 1'b0;
`endif

endmodule
`default_nettype wire
